// File: rtl/minimal_dma_axi_slave_mem.sv
// ============================================================================
// Module   : minimal_dma_axi_slave_mem
// Brief    : AXI4 INCR-burst slave backed by simple dual-port on-chip RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module minimal_dma_axi_slave_mem #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_MEM_DEPTH_LOG2   = 10
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [2:0]                        S_AXI_AWSIZE,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,

    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [2:0]                        S_AXI_ARSIZE,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int         c_STRB_W     = C_S_AXI_DATA_WIDTH / 8;
    localparam int         c_ADDR_LSB   = (C_S_AXI_DATA_WIDTH == 64) ? 3 : 2;
    localparam int         c_DEPTH      = 1 << C_MEM_DEPTH_LOG2;
    localparam logic [2:0] c_SIZE       = 3'(c_ADDR_LSB);
    localparam logic [1:0] c_BURST_INCR = 2'b01;
    localparam logic [1:0] c_RESP_OKAY  = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [c_DEPTH];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic [1:0]                  r_wstate;
    logic                        r_awready;
    logic                        r_wready;
    logic                        r_bvalid;
    logic [1:0]                  r_bresp;
    logic [C_MEM_DEPTH_LOG2-1:0] r_widx;
    logic [7:0]                  r_wcnt;
    logic [7:0]                  r_wlen;
    logic                        r_wlegal;
    logic                        r_werr;

    logic                        w_aw_hs;
    logic                        w_w_hs;
    logic                        w_w_final;
    logic                        w_wlast_bad;
    logic                        w_aw_legal;
    logic [C_MEM_DEPTH_LOG2-1:0] w_aw_idx;

    assign w_aw_hs     = r_awready && S_AXI_AWVALID;
    assign w_w_hs      = r_wready && S_AXI_WVALID;
    assign w_w_final   = (r_wcnt == r_wlen);
    assign w_wlast_bad = (S_AXI_WLAST != w_w_final);
    assign w_aw_legal  = (S_AXI_AWBURST == c_BURST_INCR) && (S_AXI_AWSIZE == c_SIZE);
    assign w_aw_idx    = S_AXI_AWADDR[c_ADDR_LSB+C_MEM_DEPTH_LOG2-1:c_ADDR_LSB];

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            r_widx    <= '0;
            r_wcnt    <= '0;
            r_wlen    <= '0;
            r_wlegal  <= 1'b0;
            r_werr    <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (w_aw_hs) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_widx    <= w_aw_idx;
                        r_wlen    <= S_AXI_AWLEN;
                        r_wcnt    <= '0;
                        r_wlegal  <= w_aw_legal;
                        r_werr    <= !w_aw_legal;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    // Burst length is governed by AWLEN; WLAST only feeds the error flag.
                    if (w_w_hs) begin
                        if (w_w_final) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || w_wlast_bad) ? c_RESP_SLVERR : c_RESP_OKAY;
                            r_wstate <= W_RESP;
                        end else begin
                            r_wcnt <= r_wcnt + 8'd1;
                            r_widx <= r_widx + 1'b1;
                            r_werr <= r_werr || w_wlast_bad;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_w_hs && r_wlegal) begin
            for (int i = 0; i < c_STRB_W; i++) begin
                if (S_AXI_WSTRB[i]) begin
                    r_mem[r_widx][i*8 +: 8] <= S_AXI_WDATA[i*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic [0:0]                    r_rstate;
    logic                          r_arready;
    logic                          r_rvalid;
    logic                          r_rlast;
    logic [1:0]                    r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [C_MEM_DEPTH_LOG2-1:0]   r_ridx;
    logic [7:0]                    r_rcnt;
    logic [7:0]                    r_rlen;
    logic                          r_rlegal;

    logic                          w_ar_hs;
    logic                          w_r_hs;
    logic                          w_ar_legal;
    logic [C_MEM_DEPTH_LOG2-1:0]   w_ar_idx;
    logic [C_MEM_DEPTH_LOG2-1:0]   w_rd_addr;
    logic                          w_rd_en;
    logic                          w_rd_legal;

    assign w_ar_hs    = r_arready && S_AXI_ARVALID;
    assign w_r_hs     = r_rvalid && S_AXI_RREADY;
    assign w_ar_legal = (S_AXI_ARBURST == c_BURST_INCR) && (S_AXI_ARSIZE == c_SIZE);
    assign w_ar_idx   = S_AXI_ARADDR[c_ADDR_LSB+C_MEM_DEPTH_LOG2-1:c_ADDR_LSB];

    // Prefetch the next beat whenever the output register is about to be consumed.
    assign w_rd_addr  = (r_rstate == R_IDLE) ? w_ar_idx   : r_ridx;
    assign w_rd_legal = (r_rstate == R_IDLE) ? w_ar_legal : r_rlegal;
    assign w_rd_en    = w_ar_hs || (w_r_hs && !r_rlast);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_rdata <= '0;
        end else if (w_rd_en) begin
            r_rdata <= w_rd_legal ? r_mem[w_rd_addr] : '0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= c_RESP_OKAY;
            r_ridx    <= '0;
            r_rcnt    <= '0;
            r_rlen    <= '0;
            r_rlegal  <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rlast   <= (S_AXI_ARLEN == 8'd0);
                        r_rresp   <= w_ar_legal ? c_RESP_OKAY : c_RESP_SLVERR;
                        r_ridx    <= w_ar_idx + 1'b1;
                        r_rcnt    <= '0;
                        r_rlen    <= S_AXI_ARLEN;
                        r_rlegal  <= w_ar_legal;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_ridx  <= r_ridx + 1'b1;
                            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                        end
                    end
                end
                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    // Address bits outside the word index are intentionally ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^{S_AXI_AWADDR, S_AXI_ARADDR};

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RLAST   = r_rlast;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_minimal_dma_axi_slave_mem.sv
// ============================================================================
// Module   : tb_minimal_dma_axi_slave_mem
// Brief    : Directed self-checking bench for minimal_dma_axi_slave_mem.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_minimal_dma_axi_slave_mem;

    logic        tb_ACLK;
    logic        tb_ARESETN;
    logic [31:0] tb_awaddr;
    logic [7:0]  tb_awlen;
    logic [2:0]  tb_awsize;
    logic [1:0]  tb_awburst;
    logic        tb_awvalid;
    logic        tb_awready;
    logic [31:0] tb_wdata;
    logic [3:0]  tb_wstrb;
    logic        tb_wlast;
    logic        tb_wvalid;
    logic        tb_wready;
    logic [1:0]  tb_bresp;
    logic        tb_bvalid;
    logic        tb_bready;
    logic [31:0] tb_araddr;
    logic [7:0]  tb_arlen;
    logic [2:0]  tb_arsize;
    logic [1:0]  tb_arburst;
    logic        tb_arvalid;
    logic        tb_arready;
    logic [31:0] tb_rdata;
    logic [1:0]  tb_rresp;
    logic        tb_rlast;
    logic        tb_rvalid;
    logic        tb_rready;

    int checks = 0;
    int errors = 0;

    logic [31:0] wdat   [4];
    logic [31:0] rexp   [4];
    int          stalls [4];

    minimal_dma_axi_slave_mem #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .C_MEM_DEPTH_LOG2   (10)
    ) dut (
        .ACLK          (tb_ACLK),
        .ARESETN       (tb_ARESETN),
        .S_AXI_AWADDR  (tb_awaddr),
        .S_AXI_AWLEN   (tb_awlen),
        .S_AXI_AWSIZE  (tb_awsize),
        .S_AXI_AWBURST (tb_awburst),
        .S_AXI_AWVALID (tb_awvalid),
        .S_AXI_AWREADY (tb_awready),
        .S_AXI_WDATA   (tb_wdata),
        .S_AXI_WSTRB   (tb_wstrb),
        .S_AXI_WLAST   (tb_wlast),
        .S_AXI_WVALID  (tb_wvalid),
        .S_AXI_WREADY  (tb_wready),
        .S_AXI_BRESP   (tb_bresp),
        .S_AXI_BVALID  (tb_bvalid),
        .S_AXI_BREADY  (tb_bready),
        .S_AXI_ARADDR  (tb_araddr),
        .S_AXI_ARLEN   (tb_arlen),
        .S_AXI_ARSIZE  (tb_arsize),
        .S_AXI_ARBURST (tb_arburst),
        .S_AXI_ARVALID (tb_arvalid),
        .S_AXI_ARREADY (tb_arready),
        .S_AXI_RDATA   (tb_rdata),
        .S_AXI_RRESP   (tb_rresp),
        .S_AXI_RLAST   (tb_rlast),
        .S_AXI_RVALID  (tb_rvalid),
        .S_AXI_RREADY  (tb_rready)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // last_mode: 0 = WLAST on final beat, 1 = also on beat 0 (early), 2 = never
    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [3:0] strb,
                             input int last_mode, input logic [1:0] exp_resp);
        int n;
        tb_awaddr  = addr;
        tb_awlen   = len;
        tb_awsize  = 3'd2;
        tb_awburst = burst;
        tb_awvalid = 1'b1;
        n = 0;
        while (tb_awready !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        check({tag, "/awready"}, 64'(tb_awready), 64'd1);
        tick();
        tb_awvalid = 1'b0;
        check({tag, "/wready_after_aw"}, 64'(tb_wready), 64'd1);
        check({tag, "/awready_busy"}, 64'(tb_awready), 64'd0);
        for (int b = 0; b <= int'(len); b++) begin
            tb_wdata  = wdat[b];
            tb_wstrb  = strb;
            tb_wvalid = 1'b1;
            case (last_mode)
                1:       tb_wlast = (b == 0) || (b == int'(len));
                2:       tb_wlast = 1'b0;
                default: tb_wlast = (b == int'(len));
            endcase
            n = 0;
            while (tb_wready !== 1'b1 && n < 16) begin
                tick();
                n++;
            end
            check({tag, "/wready_beat"}, 64'(tb_wready), 64'd1);
            tick();
        end
        tb_wvalid = 1'b0;
        tb_wlast  = 1'b0;
        check({tag, "/bvalid"}, 64'(tb_bvalid), 64'd1);
        check({tag, "/bresp"}, 64'(tb_bresp), 64'(exp_resp));
        tb_bready = 1'b1;
        tick();
        tb_bready = 1'b0;
        check({tag, "/bvalid_clear"}, 64'(tb_bvalid), 64'd0);
        check({tag, "/awready_return"}, 64'(tb_awready), 64'd1);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input logic [1:0] exp_resp);
        int n;
        tb_araddr  = addr;
        tb_arlen   = len;
        tb_arsize  = size;
        tb_arburst = burst;
        tb_arvalid = 1'b1;
        n = 0;
        while (tb_arready !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        check({tag, "/arready"}, 64'(tb_arready), 64'd1);
        tick();
        tb_arvalid = 1'b0;
        check({tag, "/rvalid_latency"}, 64'(tb_rvalid), 64'd1);
        for (int b = 0; b <= int'(len); b++) begin
            for (int s = 0; s < stalls[b]; s++) begin
                tb_rready = 1'b0;
                tick();
                check({tag, "/stall_rvalid"}, 64'(tb_rvalid), 64'd1);
                check({tag, "/stall_rdata"}, 64'(tb_rdata), 64'(rexp[b]));
                check({tag, "/stall_rlast"}, 64'(tb_rlast), 64'(b == int'(len)));
            end
            tb_rready = 1'b1;
            check({tag, "/rvalid"}, 64'(tb_rvalid), 64'd1);
            check({tag, "/rdata"}, 64'(tb_rdata), 64'(rexp[b]));
            check({tag, "/rlast"}, 64'(tb_rlast), 64'(b == int'(len)));
            check({tag, "/rresp"}, 64'(tb_rresp), 64'(exp_resp));
            tick();
        end
        tb_rready = 1'b0;
        check({tag, "/rvalid_end"}, 64'(tb_rvalid), 64'd0);
        check({tag, "/arready_end"}, 64'(tb_arready), 64'd1);
        stalls = '{0, 0, 0, 0};
    endtask

    initial begin
        tb_ARESETN = 1'b0;
        tb_awaddr  = '0;
        tb_awlen   = '0;
        tb_awsize  = 3'd2;
        tb_awburst = 2'b01;
        tb_awvalid = 1'b1;
        tb_wdata   = '0;
        tb_wstrb   = '0;
        tb_wlast   = 1'b0;
        tb_wvalid  = 1'b0;
        tb_bready  = 1'b0;
        tb_araddr  = '0;
        tb_arlen   = '0;
        tb_arsize  = 3'd2;
        tb_arburst = 2'b01;
        tb_arvalid = 1'b1;
        tb_rready  = 1'b0;
        stalls     = '{0, 0, 0, 0};

        // Reset held for four edges with both address VALIDs asserted
        repeat (4) tick();
        check("rst/awready", 64'(tb_awready), 64'd0);
        check("rst/wready",  64'(tb_wready),  64'd0);
        check("rst/bvalid",  64'(tb_bvalid),  64'd0);
        check("rst/arready", 64'(tb_arready), 64'd0);
        check("rst/rvalid",  64'(tb_rvalid),  64'd0);
        check("rst/rlast",   64'(tb_rlast),   64'd0);
        check("rst/bresp",   64'(tb_bresp),   64'd0);
        check("rst/rresp",   64'(tb_rresp),   64'd0);
        check("rst/rdata",   64'(tb_rdata),   64'd0);
        tb_awvalid = 1'b0;
        tb_arvalid = 1'b0;
        tb_ARESETN = 1'b1;
        tick();
        check("rel/awready", 64'(tb_awready), 64'd1);
        check("rel/arready", 64'(tb_arready), 64'd1);

        // Basic four-beat burst and read-back
        wdat = '{32'h11, 32'h22, 32'h33, 32'h44};
        axi_write("wr40", 32'h40, 8'd3, 2'b01, 4'hF, 0, 2'b00);
        rexp = '{32'h11, 32'h22, 32'h33, 32'h44};
        axi_read("rd40", 32'h40, 8'd3, 2'b01, 3'd2, 2'b00);

        // RREADY pattern 1,0,0,1,...: two stall cycles before beat 1
        stalls = '{0, 2, 0, 0};
        axi_read("rd40_stall", 32'h40, 8'd3, 2'b01, 3'd2, 2'b00);

        // Byte-lane strobes
        wdat = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        axi_write("wr_ones", 32'h100, 8'd0, 2'b01, 4'hF, 0, 2'b00);
        wdat = '{32'hAAAA_5555, 32'h0, 32'h0, 32'h0};
        axi_write("wr_strb", 32'h100, 8'd0, 2'b01, 4'h3, 0, 2'b00);
        rexp = '{32'hFFFF_5555, 32'h0, 32'h0, 32'h0};
        axi_read("rd_strb", 32'h100, 8'd0, 2'b01, 3'd2, 2'b00);

        // Index wrap from word 1023 to word 0
        wdat = '{32'hDEAD_0001, 32'hDEAD_0002, 32'h0, 32'h0};
        axi_write("wr_wrap", 32'hFFC, 8'd1, 2'b01, 4'hF, 0, 2'b00);
        rexp = '{32'hDEAD_0001, 32'hDEAD_0002, 32'h0, 32'h0};
        axi_read("rd_wrap", 32'hFFC, 8'd1, 2'b01, 3'd2, 2'b00);
        rexp = '{32'hDEAD_0002, 32'h0, 32'h0, 32'h0};
        axi_read("rd_idx0", 32'h0, 8'd0, 2'b01, 3'd2, 2'b00);
        axi_read("rd_upper_ignored", 32'h1000, 8'd0, 2'b01, 3'd2, 2'b00);

        // FIXED burst: accepted, SLVERR, RAM untouched
        wdat = '{32'h99, 32'h98, 32'h0, 32'h0};
        axi_write("wr_fixed", 32'h40, 8'd1, 2'b00, 4'hF, 0, 2'b10);
        rexp = '{32'h11, 32'h22, 32'h0, 32'h0};
        axi_read("rd_after_fixed", 32'h40, 8'd1, 2'b01, 3'd2, 2'b00);

        // WLAST protocol errors, then a clean burst to confirm the flag clears
        wdat = '{32'h55, 32'h66, 32'h0, 32'h0};
        axi_write("wr_early_wlast", 32'h80, 8'd1, 2'b01, 4'hF, 1, 2'b10);
        axi_write("wr_missing_wlast", 32'h80, 8'd1, 2'b01, 4'hF, 2, 2'b10);
        wdat = '{32'h77, 32'h88, 32'h0, 32'h0};
        axi_write("wr_clean", 32'h80, 8'd1, 2'b01, 4'hF, 0, 2'b00);
        rexp = '{32'h77, 32'h88, 32'h0, 32'h0};
        axi_read("rd_clean", 32'h80, 8'd1, 2'b01, 3'd2, 2'b00);

        // Illegal reads return zero data with SLVERR
        rexp = '{32'h0, 32'h0, 32'h0, 32'h0};
        axi_read("rd_fixed", 32'h40, 8'd1, 2'b00, 3'd2, 2'b10);
        axi_read("rd_badsize", 32'h40, 8'd0, 2'b01, 3'd1, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
